// File: rtl/icebus_pkg.sv
// rtl/icebus_pkg.sv - shared register map, FSM states and address helper for the IceBus poller
package icebus_pkg;

  // Motor-controller register selectors (upper byte of the Avalon address)
  localparam logic [7:0] REG_ID       = 8'h00;
  localparam logic [7:0] REG_ENCODER0 = 8'h04;
  localparam logic [7:0] REG_SETPOINT = 8'h0C;

  // Poller FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_READ   = 2'd2,
    ST_SAMPLE = 2'd3
  } poll_state_e;

  // Avalon address layout: register selector in the upper byte, motor number in the lower
  function automatic logic [15:0] icebus_addr(input logic [7:0] reg_sel, input logic [7:0] motor);
    return {reg_sel, motor};
  endfunction

endpackage

// File: rtl/icebus_poll_timer.sv
// rtl/icebus_poll_timer.sv - free-running sweep period timer with one-cycle wrap tick
module icebus_poll_timer #(
  parameter int unsigned POLL_PERIOD_CLKS = 500000
) (
  input  logic clk,
  input  logic reset,
  output logic poll_tick
);

  localparam int unsigned CW = $clog2(POLL_PERIOD_CLKS);
  localparam logic [CW-1:0] LAST_COUNT = CW'(POLL_PERIOD_CLKS - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Count 0..POLL_PERIOD_CLKS-1 and flag the wrap cycle
  always_comb begin
    poll_tick = 1'b0;
    count_d   = count_q + 1'b1;
    if (count_q == LAST_COUNT) begin
      poll_tick = 1'b1;
      count_d   = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/icebus_poller.sv
// rtl/icebus_poller.sv - periodic encoder sweep and setpoint writer over Avalon-MM
module icebus_poller
  import icebus_pkg::*;
#(
  parameter int unsigned NUMBER_OF_MOTORS = 8,
  parameter int unsigned POLL_PERIOD_CLKS = 500000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_motor,
  input  logic [31:0] cmd_setpoint,
  output logic        sample_valid,
  output logic [7:0]  sample_motor,
  output logic [31:0] sample_position,
  output logic        sweep_done,
  output logic        busy,
  output logic        poll_overrun
);

  localparam logic [7:0] LAST_MOTOR = 8'(NUMBER_OF_MOTORS - 1);

  poll_state_e state_q, state_d;
  logic [7:0]  motor_idx_q, motor_idx_d;
  logic        buf_full_q, buf_full_d;
  logic [7:0]  buf_motor_q, buf_motor_d;
  logic [31:0] buf_setpoint_q, buf_setpoint_d;
  logic        pending_q, pending_d;
  logic        sweep_active_q, sweep_active_d;
  logic        overrun_q, overrun_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        poll_tick;

  icebus_poll_timer #(
    .POLL_PERIOD_CLKS(POLL_PERIOD_CLKS)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .poll_tick(poll_tick)
  );

  assign cmd_ready       = !buf_full_q;
  assign sample_motor    = motor_idx_q;
  assign sample_position = rd_data_q;
  assign poll_overrun    = overrun_q;
  assign busy            = (state_q != ST_IDLE) || sweep_active_q || buf_full_q;

  // Next-state, bus outputs, command buffer and sweep bookkeeping
  always_comb begin
    state_d        = state_q;
    motor_idx_d    = motor_idx_q;
    buf_full_d     = buf_full_q;
    buf_motor_d    = buf_motor_q;
    buf_setpoint_d = buf_setpoint_q;
    pending_d      = pending_q;
    sweep_active_d = sweep_active_q;
    overrun_d      = overrun_q;
    rd_data_d      = rd_data_q;
    avm_address    = 16'h0000;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_writedata  = 32'h0000_0000;
    sample_valid   = 1'b0;
    sweep_done     = 1'b0;

    // Only one sweep may be outstanding; any further tick is dropped and remembered
    if (poll_tick) begin
      if (pending_q || sweep_active_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    // Capture a setpoint request only while the buffer is empty
    if (cmd_valid && !buf_full_q) begin
      buf_full_d     = 1'b1;
      buf_motor_d    = cmd_motor;
      buf_setpoint_d = cmd_setpoint;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (buf_full_q) begin
          state_d = ST_WRITE;
        end else if (sweep_active_q) begin
          state_d = ST_READ;
        end else if (pending_q) begin
          pending_d      = 1'b0;
          sweep_active_d = 1'b1;
          state_d        = ST_READ;
        end
      end
      ST_WRITE: begin
        avm_write     = 1'b1;
        avm_address   = icebus_addr(REG_SETPOINT, buf_motor_q);
        avm_writedata = buf_setpoint_q;
        if (!avm_waitrequest) begin
          buf_full_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_READ: begin
        avm_read    = 1'b1;
        avm_address = icebus_addr(REG_ENCODER0, motor_idx_q);
        if (!avm_waitrequest) begin
          rd_data_d = avm_readdata;
          state_d   = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        sample_valid = 1'b1;
        state_d      = ST_IDLE;
        if (motor_idx_q == LAST_MOTOR) begin
          motor_idx_d    = 8'd0;
          sweep_done     = 1'b1;
          sweep_active_d = 1'b0;
        end else begin
          motor_idx_d = motor_idx_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      motor_idx_q    <= 8'd0;
      buf_full_q     <= 1'b0;
      buf_motor_q    <= 8'd0;
      buf_setpoint_q <= 32'h0000_0000;
      pending_q      <= 1'b0;
      sweep_active_q <= 1'b0;
      overrun_q      <= 1'b0;
      rd_data_q      <= 32'h0000_0000;
    end else begin
      motor_idx_q    <= motor_idx_d;
      buf_full_q     <= buf_full_d;
      buf_motor_q    <= buf_motor_d;
      buf_setpoint_q <= buf_setpoint_d;
      pending_q      <= pending_d;
      sweep_active_q <= sweep_active_d;
      overrun_q      <= overrun_d;
      rd_data_q      <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_icebus_poller.sv
// tb/tb_icebus_poller.sv - scoreboard bench for the IceBus poller
module tb_icebus_poller;

  localparam int N = 8;
  localparam int P = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_waitrequest = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_motor = 8'h0;
  logic [31:0] cmd_setpoint = 32'h0;
  logic        sample_valid;
  logic [7:0]  sample_motor;
  logic [31:0] sample_position;
  logic        sweep_done;
  logic        busy;
  logic        poll_overrun;

  always #5 clk = ~clk;

  icebus_poller #(
    .NUMBER_OF_MOTORS(N),
    .POLL_PERIOD_CLKS(P)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_motor      (cmd_motor),
    .cmd_setpoint   (cmd_setpoint),
    .sample_valid   (sample_valid),
    .sample_motor   (sample_motor),
    .sample_position(sample_position),
    .sweep_done     (sweep_done),
    .busy           (busy),
    .poll_overrun   (poll_overrun)
  );

  typedef struct packed {
    logic [7:0]  motor;
    logic [31:0] pos;
  } smp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [7:0]  sis;
  } wr_t;

  smp_t sq[$];
  wr_t  wq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int rd_wait = 1;
  int wr_wait = 1;
  int acc_cnt = 0;
  int cyc = 0;
  int rd_cycles = 0;
  int rd_start = 0;
  int sis = 0;
  int sweeps = 0;
  int writes = 0;
  int last_wr_cyc = -100;
  logic rd_busy = 1'b0;
  logic rd_unstable = 1'b0;
  logic rw_both = 1'b0;
  logic [15:0] rd_addr = 16'h0;

  // Slave model and output monitors, evaluated on the falling edge
  always @(negedge clk) begin
    smp_t e;
    wr_t  w;
    int   limit;
    cyc++;
    if (reset) begin
      acc_cnt = 0;
      rd_busy = 1'b0;
      avm_waitrequest = 1'b0;
    end else begin
      if (sample_valid) begin
        chk("sample_expected", sq.size() != 0, 1);
        if (sq.size() != 0) begin
          e = sq.pop_front();
          chk("sample_motor", sample_motor, e.motor);
          chk("sample_position", sample_position, e.pos);
          chk("sweep_done_pos", sweep_done, e.motor == 8'(N - 1));
          chk("sample_latency", cyc - rd_start, rd_wait + 1);
        end
        sis++;
      end
      if (sweep_done) begin
        chk("sweep_len", sis, N);
        sis = 0;
        sweeps++;
      end
      if (avm_read || avm_write) begin
        limit = avm_read ? rd_wait : wr_wait;
        if (acc_cnt < limit) begin
          avm_waitrequest = 1'b1;
          acc_cnt++;
        end else begin
          avm_waitrequest = 1'b0;
          acc_cnt = 0;
        end
        avm_readdata = 32'(1000 * int'(avm_address[7:0]));
      end else begin
        avm_waitrequest = 1'b0;
        acc_cnt = 0;
      end
      if (avm_read) begin
        if (avm_write) rw_both = 1'b1;
        if (!rd_busy) begin
          rd_busy = 1'b1;
          rd_start = cyc;
          rd_addr = avm_address;
          rd_cycles = 0;
          rd_unstable = 1'b0;
        end
        rd_cycles++;
        if (avm_address !== rd_addr) rd_unstable = 1'b1;
        if (!avm_waitrequest) begin
          chk("read_len", rd_cycles, rd_wait + 1);
          chk("read_addr_stable", rd_unstable, 0);
          chk("rw_exclusive", rw_both, 0);
          rd_busy = 1'b0;
        end
      end
      if (avm_write && !avm_waitrequest) begin
        chk("write_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          chk("write_addr", avm_address, w.addr);
          chk("write_data", avm_writedata, w.data);
          chk("write_order", sis, w.sis);
        end
        writes++;
        last_wr_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_sweep();
    for (int m = 0; m < N; m++) begin
      sq.push_back('{motor: 8'(m), pos: 32'(1000 * m)});
    end
  endtask

  task automatic wait_sweeps(input int target, input int limit);
    int k;
    k = 0;
    while (sweeps < target && k < limit) begin
      tick(1);
      k++;
    end
    chk("sweep_count", sweeps, target);
  endtask

  task automatic send_cmd(input logic [7:0] motor, input logic [31:0] sp);
    int k;
    cmd_valid = 1'b1;
    cmd_motor = motor;
    cmd_setpoint = sp;
    k = 0;
    while (!cmd_ready && k < 200) begin
      tick(1);
      k++;
    end
    chk("cmd_handshake", cmd_ready, 1);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int k;
    int wcount;
    tick(2);
    chk("rst_avm_read", avm_read, 0);
    chk("rst_avm_write", avm_write, 0);
    chk("rst_avm_address", avm_address, 16'h0000);
    chk("rst_avm_writedata", avm_writedata, 32'h0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_sample_motor", sample_motor, 8'h0);
    chk("rst_sample_position", sample_position, 32'h0);
    chk("rst_sweep_done", sweep_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", poll_overrun, 0);

    // Plain sweep, one wait cycle per access
    push_sweep();
    reset = 1'b0;
    wait_sweeps(1, 400);
    tick(3);
    chk("idle_busy", busy, 0);
    chk("idle_overrun", poll_overrun, 0);
    chk("sweep1_drained", sq.size(), 0);

    // Setpoint command arriving while motor 2 is being read
    push_sweep();
    k = 0;
    while (!(avm_read && avm_address == 16'h0402) && k < 300) begin
      tick(1);
      k++;
    end
    chk("m2_read_seen", avm_address, 16'h0402);
    wq.push_back('{addr: 16'h0C03, data: 32'hFFFF_FE0C, sis: 8'd3});
    send_cmd(8'd3, 32'(-500));
    wait_sweeps(2, 300);
    chk("interleave_write_done", wq.size(), 0);

    // Second command held while the buffer is still occupied
    push_sweep();
    wq.push_back('{addr: 16'h0C05, data: 32'h1234_5678, sis: 8'd0});
    wq.push_back('{addr: 16'h0CAA, data: 32'hDEAD_BEEF, sis: 8'd0});
    send_cmd(8'h05, 32'h1234_5678);
    cmd_valid = 1'b1;
    cmd_motor = 8'hAA;
    cmd_setpoint = 32'hDEAD_BEEF;
    chk("ready_when_full", cmd_ready, 0);
    chk("busy_when_full", busy, 1);
    k = 0;
    while (!cmd_ready && k < 100) begin
      tick(1);
      k++;
    end
    chk("accept_cycle", cyc, last_wr_cyc + 1);
    tick(1);
    cmd_valid = 1'b0;
    wait_sweeps(3, 300);
    chk("held_writes_done", wq.size(), 0);
    chk("overrun_still_clear", poll_overrun, 0);

    // Long waitrequest on every read
    rd_wait = 5;
    push_sweep();
    wait_sweeps(4, 300);
    chk("slow_sweep_drained", sq.size(), 0);
    rd_wait = 1;

    // Reset while a buffered setpoint is being written
    wr_wait = 10;
    send_cmd(8'h01, 32'h0000_0055);
    k = 0;
    while (!avm_write && k < 20) begin
      tick(1);
      k++;
    end
    tick(2);
    chk("in_write", avm_write, 1);
    chk("buffer_full_in_write", cmd_ready, 0);
    wcount = writes;
    reset = 1'b1;
    #1;
    chk("rstw_avm_write", avm_write, 0);
    chk("rstw_cmd_ready", cmd_ready, 1);
    chk("rstw_busy", busy, 0);
    tick(2);
    reset = 1'b0;
    wr_wait = 1;
    tick(40);
    chk("no_write_after_reset", writes, wcount);
    chk("post_reset_write_idle", avm_write, 0);
    chk("post_reset_overrun", poll_overrun, 0);

    // Sweep longer than the poll period
    rd_wait = 20;
    push_sweep();
    wait_sweeps(5, 500);
    chk("overrun_set", poll_overrun, 1);
    push_sweep();
    wait_sweeps(6, 500);
    chk("overrun_sticky", poll_overrun, 1);
    chk("overrun_sweeps_drained", sq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icebus_poller.md
ICEBUS_POLLER -- requirements
Module: icebus_poller

Interface
REQ-001 Parameter NUMBER_OF_MOTORS, default 8, motors polled per sweep (1..255).
REQ-002 Parameter POLL_PERIOD_CLKS, default 500000, clocks between sweep triggers (>=2).
REQ-003 Port clk in 1: clock; all logic on rising edge.
REQ-004 Port reset in 1: reset, asynchronous, active-high.
REQ-005 Port avm_address out 16: Avalon-MM address = {reg[7:0], motor[7:0]}.
REQ-006 Port avm_read out 1, avm_write out 1, avm_writedata out 32: Avalon-MM master controls.
REQ-007 Port avm_readdata in 32, avm_waitrequest in 1: Avalon-MM slave response.
REQ-008 Port cmd_valid in 1, cmd_ready out 1, cmd_motor in 8, cmd_setpoint in 32: setpoint write request, valid/ready.
REQ-009 Port sample_valid out 1, sample_motor out 8, sample_position out 32: encoder0 result stream, no backpressure.
REQ-010 Port sweep_done out 1 (one-cycle pulse), busy out 1, poll_overrun out 1 (sticky).

Function
REQ-011 Internal timer SHALL count 0..POLL_PERIOD_CLKS-1, wrap to 0, assert poll_tick for one cycle at wrap.
REQ-012 poll_tick SHALL set a single poll_pending flag; a tick while poll_pending is already set or a sweep is running SHALL set poll_overrun and be dropped (no queuing beyond one).
REQ-013 One-entry command buffer: cmd_ready = buffer empty; handshake on cmd_valid&&cmd_ready captures motor/setpoint; buffer frees in cycle write completes.
REQ-014 FSM states: IDLE, WRITE, READ, SAMPLE. Arbitration in IDLE: buffered command first, else next motor of active/pending sweep, else stay IDLE.
REQ-015 WRITE: avm_write=1, avm_address={8'h0C, cmd_motor}, avm_writedata=cmd_setpoint, held stable until cycle with avm_waitrequest=0; then -> IDLE.
REQ-016 READ: avm_read=1, avm_address={8'h04, motor_idx}, held stable until avm_waitrequest=0; avm_readdata captured that cycle; -> SAMPLE.
REQ-017 SAMPLE: sample_valid=1 for exactly one cycle with captured data and motor_idx; motor_idx increments; -> IDLE.
REQ-018 When motor_idx wraps from NUMBER_OF_MOTORS-1 to 0, sweep_done SHALL pulse in the SAMPLE cycle and sweep ends; poll_pending consumed when sweep starts.
REQ-019 avm_read and avm_write SHALL never be asserted together; both 0 in IDLE and SAMPLE.
REQ-020 Commands interleave between motor reads of a sweep (never abort a transaction in flight).
REQ-021 busy = (state != IDLE) || sweep active || buffer full.
REQ-022 Minimum latency: read with zero waitrequest completes READ in 1 cycle; sample_valid 1 cycle later; slave with one wait cycle -> sample_valid 2 cycles after READ entry.
REQ-023 poll_overrun clears only on reset.

Reset
REQ-024 On reset: FSM IDLE, timer 0, motor_idx 0, buffer empty, poll_pending 0, sweep inactive.
REQ-025 Reset outputs: avm_read 0, avm_write 0, avm_address 0, avm_writedata 0, cmd_ready 1, sample_valid 0, sample_motor 0, sample_position 0, sweep_done 0, busy 0, poll_overrun 0.
REQ-026 Reset mid-transaction SHALL drop the transaction and buffered command immediately (asynchronous).

Structure
REQ-027 Package icebus_pkg SHALL hold register constants REG_ENCODER0=8'h04, REG_SETPOINT=8'h0C, REG_ID=8'h00, and FSM state enum.
REQ-028 Sub-module icebus_poll_timer SHALL implement REQ-011 (period parameter, tick output).

Verification
REQ-029 Slave model, waitrequest=1 for 1 cycle per access, encoder0[m]=1000*m; POLL_PERIOD_CLKS=100 -> 8 samples motor 0..7 values 0..7000, sweep_done once after motor 7.
REQ-030 cmd motor 3 setpoint -500 during sweep at motor 2 read -> write addr 0x0C03 data 0xFFFFFE0C issued after motor 2 sample, before motor 3 read.
REQ-031 Slave holds waitrequest 5 cycles on read -> avm_address/avm_read stable all 6 cycles, one sample only.
REQ-032 POLL_PERIOD_CLKS=10 with 4-cycle-wait slave -> poll_overrun set, no duplicated/overlapping sweeps.
REQ-033 Assert reset during WRITE with cmd buffered -> next cycle avm_write 0, cmd_ready 1, no write completes after reset release without new cmd.
REQ-034 cmd_valid held with buffer full -> cmd_ready 0, data held, accepted the cycle after previous write completes.
